timestamp_fifo_rcv: RTL and testbench
=====================================

Name: timestamp_fifo_rcv

Overview:
- Consumer of the byte-serialized timestamp stream: per-channel ts_stb/ts_data from the sync block, or logger stb/data.
- Deserializes each 8-byte message (s0,s1,s2,s3,u0,u1,u2,u3) into 32-bit seconds and 20-bit microseconds.
- Queues results in a small show-ahead FIFO, so frame-header and compressor logic can pop one timestamp per frame.
- Absorbs jitter between frame-sync snapshots and header consumption; flags overflow.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (entries = 2**DEPTH_LOG2, range 1..5)

Ports:
mclk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
ts_stb  input  1  one-cycle pulse, one clock before first message byte
ts_data  input  8  message byte, valid in the 8 cycles following ts_stb
clr  input  1  synchronous clear: empties FIFO, clears sticky flags, aborts message in progress
ts_ack  input  1  pop head entry; ignored when ts_valid=0
ts_valid  output  1  head entry present
ts_sec  output  32  head entry seconds
ts_usec  output  20  head entry microseconds
ts_count  output  DEPTH_LOG2+1  number of stored entries
busy  output  1  message reception in progress
overflow  output  1  sticky: a complete message was dropped because FIFO was full

Behaviour:
- Reset (rst=1 at a clock edge) sets all outputs to 0 (ts_valid, ts_sec, ts_usec, ts_count, busy, overflow) and empties the FIFO. A partial message is discarded.
- clr has the same effect as rst except it is command-driven; rst has priority.
- Receiver FSM states:
  - IDLE → RCV on ts_stb.
  - RCV uses 3-bit byte index b=0..7; b increments every cycle.
  - Byte b is captured into a shift/assembly register: b0..3 → sec[7:0]..sec[31:24]; b4 → usec[7:0]; b5 → usec[15:8]; b6 → usec[19:16] from ts_data[3:0]; b7 (u3) is ignored.
  - On the cycle b=7 is sampled: push the assembled entry (subject to the full check), return to IDLE.
- Restart rule: a ts_stb while in RCV aborts the current message without pushing and restarts with b=0 on the next cycle. No flag is raised.
- busy=1 from the cycle after ts_stb through the cycle in which b=7 is sampled.
- Latency: ts_stb at cycle T; bytes at T+1..T+8; entry written at the edge ending T+8. With the FIFO previously empty, ts_valid=1 and the head data are valid in cycle T+9.
- FIFO:
  - Circular buffer with write/read pointers of DEPTH_LOG2 bits and a count of DEPTH_LOG2+1 bits.
  - Outputs are show-ahead and registered from the head entry.
  - Pointers wrap modulo 2**DEPTH_LOG2.
- Push when full (ts_count == 2**DEPTH_LOG2) with no pop in the same cycle: entry dropped, overflow←1, contents unchanged.
- Simultaneous push and pop:
  - When full: allowed, count unchanged, no overflow.
  - When count==1: head advances to the new entry and ts_valid stays 1.
- Pop when empty: no effect; count never underflows.
- ts_count updates on the same edge as the push/pop that changes it.
- ts_sec/ts_usec hold their last value when ts_valid=0; the bench must not check them then.

Optional Feature:
- Macro: TIMESTAMP_FIFO_RCV_USEC_CHECK_EN.
- Defined:
  - Adds a sticky output fmt_err (1 bit, reset 0, cleared by clr).
  - A message is dropped (no push, fmt_err←1) if u2[7:4]≠0, or u3≠0, or the assembled usec ≥ 1000000.
  - A dropped message does not affect overflow.
- Undefined:
  - No fmt_err port.
  - usec = {u2[3:0],u1,u0}; upper nibble of u2 and u3 are ignored; every complete message is pushed.

Test Plan:
- Single message: ts_stb, then bytes 78,56,34,12,40,42,0F,00 → ts_valid at T+9; ts_sec=32'h12345678; ts_usec=20'hF4240 (only with the check undefined; with the check defined → fmt_err=1, no push). Then usec bytes 3F,42,0F,00 → ts_usec=20'hF423F=999999, ts_valid=1.
- Fill DEPTH_LOG2=2 with 4 messages (sec=1..4), send a 5th (sec=5) with no ack → ts_count=4, overflow=1; pops then return sec 1,2,3,4; ts_valid=0 after the 4th pop; ts_count=0.
- With full FIFO, assert ts_ack in the same cycle as the last byte of message sec=9 → no overflow, ts_count stays 4, pop order 2,3,4,9.
- ts_stb reissued at b=3 of a message, followed by a full message sec=AABBCCDD → exactly one entry, sec=AABBCCDD, busy continuous.
- rst asserted at b=5 of a message and at ts_count=2 → all outputs 0 next cycle; a following complete message → ts_count=1 with correct data.
- clr while overflow=1 and ts_count=3 → ts_count=0, overflow=0, ts_valid=0 next cycle; ack while empty → ts_count stays 0.

Source files
------------

// File: rtl/timestamp_fifo_rcv.sv
// Byte-serial timestamp receiver feeding a show-ahead FIFO of {sec, usec} entries.
// Optional usec format check when TIMESTAMP_FIFO_RCV_USEC_CHECK_EN is defined (adds fmt_err).
module timestamp_fifo_rcv #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  ts_stb,
  input  logic [7:0]            ts_data,
  input  logic                  clr,
  input  logic                  ts_ack,
  output logic                  ts_valid,
  output logic [31:0]           ts_sec,
  output logic [19:0]           ts_usec,
  output logic [DEPTH_LOG2:0]   ts_count,
  output logic                  busy,
  output logic                  overflow
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
  ,
  output logic                  fmt_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  typedef enum logic {S_IDLE, S_RCV} state_t;

  state_t                state_q, state_d;
  logic [2:0]            b_q, b_d;
  logic [31:0]           sec_q, sec_d;
  logic [19:0]           usec_q, usec_d;
  logic                  push_req, push_msg;

  logic [51:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           head_sec_q;
  logic [19:0]           head_usec_q;
  logic [51:0]           new_entry, head_d;
  logic                  overflow_q;
  logic                  full, pop, push, ovf_set;

`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
  logic hi_err_q, hi_err_d;
  logic fmt_err_q;
  logic fmt_bad;
`endif

  // Receiver: byte index walks 0..7; a strobe mid-message restarts at byte 0.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    sec_d    = sec_q;
    usec_d   = usec_q;
    push_req = 1'b0;
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
    hi_err_d = hi_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ts_stb) begin
          state_d = S_RCV;
          b_d     = '0;
        end
      end
      S_RCV: begin
        if (ts_stb) begin
          b_d = '0;
        end else begin
          b_d = b_q + 3'd1;
          case (b_q)
            3'd0: sec_d[7:0]    = ts_data;
            3'd1: sec_d[15:8]   = ts_data;
            3'd2: sec_d[23:16]  = ts_data;
            3'd3: sec_d[31:24]  = ts_data;
            3'd4: usec_d[7:0]   = ts_data;
            3'd5: usec_d[15:8]  = ts_data;
            3'd6: begin
              usec_d[19:16] = ts_data[3:0];
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
              hi_err_d = |ts_data[7:4];
`endif
            end
            default: begin
              push_req = 1'b1;
              state_d  = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
  // ts_data here is u3, sampled in the same cycle as the push request.
  assign fmt_bad  = hi_err_q | (|ts_data) | (usec_q >= 20'd1000000);
  assign push_msg = push_req & ~fmt_bad;
  assign fmt_err  = fmt_err_q;
`else
  assign push_msg = push_req;
`endif

  assign new_entry = {sec_q, usec_q};
  assign full      = (count_q == FULL_CNT);
  assign pop       = ts_ack & (count_q != '0);
  assign push      = push_msg & (~full | pop);
  assign ovf_set   = push_msg & full & ~pop;

  // FIFO bookkeeping; the new entry bypasses memory when it becomes the head.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
    if (push && (wptr_q == rptr_d)) head_d = new_entry;
    else                            head_d = mem_q[rptr_d];
  end

  always_ff @(posedge mclk) begin
    if (rst || clr) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      head_sec_q  <= '0;
      head_usec_q <= '0;
      overflow_q  <= 1'b0;
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
      hi_err_q    <= 1'b0;
      fmt_err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (count_d != '0) begin
        head_sec_q  <= head_d[51:20];
        head_usec_q <= head_d[19:0];
      end
      if (ovf_set) overflow_q <= 1'b1;
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
      hi_err_q <= hi_err_d;
      if (push_req && fmt_bad) fmt_err_q <= 1'b1;
`endif
    end
  end

  always_ff @(posedge mclk) begin
    sec_q  <= sec_d;
    usec_q <= usec_d;
    if (push) mem_q[wptr_q] <= new_entry;
  end

  assign ts_valid = (count_q != '0);
  assign ts_sec   = head_sec_q;
  assign ts_usec  = head_usec_q;
  assign ts_count = count_q;
  assign busy     = (state_q == S_RCV);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_timestamp_fifo_rcv.sv
// Self-checking bench for timestamp_fifo_rcv: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_timestamp_fifo_rcv;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic          mclk = 1'b0;
  logic          rst, ts_stb, clr, ts_ack;
  logic [7:0]    ts_data;
  logic          ts_valid, busy, overflow;
  logic [31:0]   ts_sec;
  logic [19:0]   ts_usec;
  logic [DL2:0]  ts_count;
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
  logic          fmt_err;
`endif

  always #5 mclk = ~mclk;

  timestamp_fifo_rcv #(.DEPTH_LOG2(DL2)) dut (
    .mclk(mclk),
    .rst(rst),
    .ts_stb(ts_stb),
    .ts_data(ts_data),
    .clr(clr),
    .ts_ack(ts_ack),
    .ts_valid(ts_valid),
    .ts_sec(ts_sec),
    .ts_usec(ts_usec),
    .ts_count(ts_count),
    .busy(busy),
    .overflow(overflow)
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
    ,
    .fmt_err(fmt_err)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of {sec, usec} entries plus sticky flags.
  logic [51:0] expq[$];
  logic        exp_ovf = 1'b0;
  logic        exp_fmt = 1'b0;

  typedef struct {
    logic [31:0] sec;
    logic [7:0]  u0, u1, u2, u3;
    logic [31:0] exp_sec;
    logic [19:0] exp_usec;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic model_msg(input logic [31:0] sec, input logic [7:0] u0, input logic [7:0] u1,
                           input logic [7:0] u2, input logic [7:0] u3, input bit ack);
    logic [19:0] us;
    bit bad, was_full, popped;
    us = {u2[3:0], u1, u0};
    bad = 1'b0;
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
    bad = (u2[7:4] != 4'd0) || (u3 != 8'd0) || (us >= 20'd1000000);
`endif
    was_full = (expq.size() == DEPTH);
    popped   = ack && (expq.size() > 0);
    if (popped) expq.delete(0);
    if (bad) exp_fmt = 1'b1;
    else if (was_full && !popped) exp_ovf = 1'b1;
    else expq.push_back({sec, us});
  endtask

  task automatic send_msg(input logic [31:0] sec, input logic [7:0] u0, input logic [7:0] u1,
                          input logic [7:0] u2, input logic [7:0] u3, input bit ack_last);
    logic [7:0] by[8];
    by = '{sec[7:0], sec[15:8], sec[23:16], sec[31:24], u0, u1, u2, u3};
    ts_stb = 1'b1;
    step();
    ts_stb = 1'b0;
    for (int b = 0; b < 8; b++) begin
      ts_data = by[b];
      ts_ack  = (b == 7) && ack_last;
      step();
    end
    ts_ack = 1'b0;
    model_msg(sec, u0, u1, u2, u3, ack_last);
  endtask

  task automatic pop_one();
    ts_ack = 1'b1;
    step();
    ts_ack = 1'b0;
    if (expq.size() > 0) expq.delete(0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    expq.delete();
    exp_ovf = 1'b0;
    exp_fmt = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, ts_valid, expq.size() != 0);
    chk({tag, ".count"}, ts_count, expq.size());
    chk({tag, ".ovf"}, overflow, exp_ovf);
    chk({tag, ".busy"}, busy, 1'b0);
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
    chk({tag, ".fmt"}, fmt_err, exp_fmt);
`endif
    if (expq.size() != 0) begin
      chk({tag, ".sec"}, ts_sec, expq[0][51:20]);
      chk({tag, ".usec"}, ts_usec, expq[0][19:0]);
    end
  endtask

  initial begin
    logic [7:0]  m1[8];
    logic [31:0] order[4];
    logic [7:0]  rb[8];

    rst = 1'b1; clr = 1'b0; ts_stb = 1'b0; ts_ack = 1'b0; ts_data = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("rst.valid", ts_valid, 1'b0);
    chk("rst.count", ts_count, 0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.ovf", overflow, 1'b0);
    chk("rst.sec", ts_sec, 32'h0);
    chk("rst.usec", ts_usec, 20'h0);

    // Single message with latency checks
    m1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h40, 8'h42, 8'h0F, 8'h00};
    ts_stb = 1'b1;
    step();
    ts_stb = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("t1.busy", busy, 1'b1);
      chk("t1.early_valid", ts_valid, 1'b0);
      ts_data = m1[b];
      step();
    end
    model_msg(32'h12345678, 8'h40, 8'h42, 8'h0F, 8'h00, 1'b0);
`ifdef TIMESTAMP_FIFO_RCV_USEC_CHECK_EN
    chk("t1.fmt_err", fmt_err, 1'b1);
    chk("t1.dropped", ts_valid, 1'b0);
`else
    chk("t1.valid", ts_valid, 1'b1);
    chk("t1.sec", ts_sec, 32'h12345678);
    chk("t1.usec", ts_usec, 20'hF4240);
`endif
    check_state("t1");
    pop_one();
    send_msg(32'h12345678, 8'h3F, 8'h42, 8'h0F, 8'h00, 1'b0);
    chk("t1b.valid", ts_valid, 1'b1);
    chk("t1b.usec", ts_usec, 20'd999999);
    check_state("t1b");
    do_clr();

    // Table-driven single-entry vectors
    tbl[0] = '{32'h12345678, 8'h3F, 8'h42, 8'h0F, 8'h00, 32'h12345678, 20'hF423F};
    tbl[1] = '{32'hDEADBEEF, 8'h01, 8'h00, 8'h00, 8'h00, 32'hDEADBEEF, 20'h00001};
    tbl[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 20'h00000};
    tbl[3] = '{32'hFFFFFFFF, 8'h01, 8'h02, 8'h03, 8'h00, 32'hFFFFFFFF, 20'h30201};
    tbl[4] = '{32'h80000001, 8'h00, 8'h00, 8'h0A, 8'h00, 32'h80000001, 20'hA0000};
    for (int i = 0; i < 5; i++) begin
      send_msg(tbl[i].sec, tbl[i].u0, tbl[i].u1, tbl[i].u2, tbl[i].u3, 1'b0);
      chk($sformatf("tbl%0d.valid", i), ts_valid, 1'b1);
      chk($sformatf("tbl%0d.count", i), ts_count, 1);
      chk($sformatf("tbl%0d.sec", i), ts_sec, tbl[i].exp_sec);
      chk($sformatf("tbl%0d.usec", i), ts_usec, tbl[i].exp_usec);
      pop_one();
      chk($sformatf("tbl%0d.empty", i), ts_valid, 1'b0);
    end

    // Fill, overflow, drain
    for (int i = 1; i <= 5; i++) send_msg(i, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2.count", ts_count, 4);
    chk("t2.ovf", overflow, 1'b1);
    check_state("t2");
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t2.pop%0d", i), ts_sec, i);
      pop_one();
    end
    chk("t2.valid_end", ts_valid, 1'b0);
    chk("t2.count_end", ts_count, 0);

    // Push and pop together while full
    do_clr();
    for (int i = 1; i <= 4; i++) send_msg(i, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    send_msg(32'd9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t3.ovf", overflow, 1'b0);
    chk("t3.count", ts_count, 4);
    order = '{32'd2, 32'd3, 32'd4, 32'd9};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3.pop%0d", i), ts_sec, order[i]);
      pop_one();
    end
    check_state("t3");

    // Restart: second strobe at byte 3
    ts_stb = 1'b1;
    step();
    ts_stb = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk("t4.busy_a", busy, 1'b1);
      ts_data = 8'h11 * (b + 1);
      step();
    end
    chk("t4.busy_b", busy, 1'b1);
    ts_stb = 1'b1;
    ts_data = 8'h44;
    step();
    ts_stb = 1'b0;
    rb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int b = 0; b < 8; b++) begin
      chk("t4.busy_c", busy, 1'b1);
      ts_data = rb[b];
      step();
    end
    expq.push_back({32'hAABBCCDD, 20'h00001});
    chk("t4.count", ts_count, 1);
    chk("t4.sec", ts_sec, 32'hAABBCCDD);
    check_state("t4");
    do_clr();

    // Reset mid-message with two stored entries
    send_msg(32'h100, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    send_msg(32'h200, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t5.count_pre", ts_count, 2);
    ts_stb = 1'b1;
    step();
    ts_stb = 1'b0;
    for (int b = 0; b < 5; b++) begin
      ts_data = 8'h5A;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq.delete();
    exp_ovf = 1'b0;
    exp_fmt = 1'b0;
    chk("t5.valid", ts_valid, 1'b0);
    chk("t5.count", ts_count, 0);
    chk("t5.busy", busy, 1'b0);
    chk("t5.ovf", overflow, 1'b0);
    chk("t5.sec", ts_sec, 32'h0);
    chk("t5.usec", ts_usec, 20'h0);
    send_msg(32'h5555AAAA, 8'h45, 8'h23, 8'h01, 8'h00, 1'b0);
    chk("t5.count_post", ts_count, 1);
    chk("t5.sec_post", ts_sec, 32'h5555AAAA);
    chk("t5.usec_post", ts_usec, 20'h12345);

    // Clear with overflow set and three entries
    do_clr();
    for (int i = 0; i < 5; i++) send_msg(32'h10 + i, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    pop_one();
    chk("t6.ovf_pre", overflow, 1'b1);
    chk("t6.count_pre", ts_count, 3);
    do_clr();
    chk("t6.count", ts_count, 0);
    chk("t6.ovf", overflow, 1'b0);
    chk("t6.valid", ts_valid, 1'b0);
    pop_one();
    chk("t6.count_ack", ts_count, 0);

    // Randomized traffic against the model
    do_clr();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0, 1: send_msg($urandom(), 8'($urandom()), 8'($urandom()), 8'($urandom_range(0, 31)),
                       ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00,
                       1'($urandom_range(0, 1)));
        2: pop_one();
        default: step();
      endcase
      check_state($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
